scan_sequencer: RTL and testbench
=================================

// Module: scan_sequencer
// PURPOSE
//   Generates the 3-bit channel select that drives the 3x8 decoder stage directly downstream.
//   Steps sel through channels 0..7 at a programmable rate, so the decoder yields a rotating one-hot strobe.
//   Scans continuously or as single frames; supports controlled stop at frame boundary.
// PARAMETERS
//   DIV      16   clk cycles per channel dwell (>=1); DIV=1 advances every cycle
//   CNT_W    8    prescaler counter width; must satisfy 2**CNT_W >= DIV
// PORTS
//   clk         in   1  system clock, rising edge
//   nrst        in   1  asynchronous active-low reset
//   start       in   1  1-cycle request to begin scanning (sampled in IDLE only)
//   stop        in   1  request to end scanning after current frame completes
//   one_shot    in   1  sampled with start: 1 = single frame, 0 = continuous
//   sel         out  3  channel index to decoder A[2:0]
//   sel_valid   out  1  high while sel is a live channel (decoder output meaningful)
//   frame_done  out  1  1-cycle pulse when last channel of a frame ends its dwell
//   busy        out  1  high in RUN or DRAIN
// BEHAVIOUR
//   - Reset (nrst=0, async): state=IDLE, sel=0, sel_valid=0, frame_done=0, busy=0, prescaler=0, mode latch=0.
//   - States: IDLE, RUN, DRAIN. All outputs registered; no combinational path input->output.
//   - IDLE: start=1 & stop=0 -> RUN next cycle; sel=0, prescaler=0, mode latched from one_shot.
//     start & stop together in IDLE: stop wins, remain IDLE.
//   - RUN/DRAIN: prescaler counts 0..DIV-1; at DIV-1 ("tick") prescaler->0 and sel advances.
//     Each channel held exactly DIV cycles; sel_valid=1 throughout. First channel 0 visible cycle after start.
//   - Wrap: tick with sel=7 -> frame end: frame_done=1 for that cycle+1 (registered, 1 cycle), sel->0.
//     RUN continuous: stay RUN, next frame starts at channel 0 with no gap cycle.
//     RUN one_shot, or DRAIN: -> IDLE, sel_valid=0, busy=0, sel=0.
//   - stop=1 in RUN -> DRAIN next cycle; current frame completes normally then IDLE. stop in DRAIN/IDLE: no effect.
//   - start while busy ignored. one_shot only sampled in IDLE.
//   - Reset mid-scan: immediate IDLE, no frame_done pulse.
//   - Frame length = 8*DIV cycles; start-to-frame_done latency = 8*DIV cycles.
// CONFIGURATION
//   SCAN_MASK_EN defined: adds port ch_mask in 8 (bit i=1 -> channel i skipped).
//     Advance goes to next unmasked channel ascending; wrap occurs when no higher unmasked channel remains.
//     Frame start selects lowest unmasked channel. ch_mask=8'hFF: start ignored, stay IDLE;
//     mask becomes all-ones while busy -> finish current dwell, frame_done, IDLE.
//     ch_mask sampled at each tick (and at start); mid-dwell changes do not cut the dwell.
//   SCAN_MASK_EN undefined: no ch_mask port; all 8 channels scanned in order.
// STRUCTURE
//   Package scan_pkg: SEL_W=3, NUM_CH=8, state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
//   Sub-module tick_gen (parameters DIV, CNT_W): prescaler with clear input and 1-cycle tick output.
//   Top: FSM + sel register + next-channel logic (mask priority search under SCAN_MASK_EN).
// TESTING
//   1 Reset: nrst=0 while RUN at sel=5 -> all outputs 0 same cycle (async), IDLE after release.
//   2 DIV=2, start, one_shot=1 -> sel 0,0,1,1..7,7; frame_done 1 pulse at cycle 16; busy low after.
//   3 one_shot=0, stop asserted at sel=3 -> sel continues to 7, frame_done once, IDLE; no second frame.
//   4 start+stop same cycle in IDLE -> remains IDLE, sel_valid=0; start during RUN -> sel sequence unchanged.
//   5 DIV=1 continuous -> sel changes every cycle 0..7,0..; frame_done every 8th cycle, no gap.
//   6 SCAN_MASK_EN, ch_mask=8'b1010_0101 -> sel sequence 1,3,4,6 then wrap; ch_mask=8'hFF + start -> stays IDLE.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: channel/select widths, FSM
// state encoding and the unmasked-channel priority search helpers.
package scan_pkg;

  localparam int SEL_W  = 3;
  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Result of a channel search: whether a candidate exists and which one.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] ch;
  } ch_pick_t;

  // Lowest channel whose mask bit is clear (frame start channel).
  function automatic ch_pick_t lowest_unmasked(input logic [NUM_CH-1:0] mask);
    ch_pick_t pick;
    pick = '0;
    // Scan downward so the last hit, i.e. the lowest index, wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        pick.found = 1'b1;
        pick.ch    = SEL_W'(i);
      end
    end
    return pick;
  endfunction

  // Lowest unmasked channel strictly above cur; found=0 means the frame wraps.
  function automatic ch_pick_t higher_unmasked(input logic [NUM_CH-1:0] mask,
                                               input logic [SEL_W-1:0]  cur);
    ch_pick_t pick;
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!mask[i] && (i > int'(cur))) begin
        pick.found = 1'b1;
        pick.ch    = SEL_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/scan_sequencer_tick_gen.sv
// Dwell prescaler: counts 0..DIV-1 while enabled and pulses tick on the
// last count. Held at zero while clr is high (sequencer idle).
module tick_gen #(
  parameter int DIV   = 16,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick marks the final cycle of a dwell; DIV=1 gives a tick every cycle.
  assign tick = !clr && (cnt_q == LAST);

  // Next prescaler value: restart after the last count or when cleared.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer top: steps a 3-bit decoder select through channels 0..7,
// holding each for DIV clocks, in continuous or single-frame mode with a
// stop-at-frame-boundary drain. All outputs are registered.
// Optional feature macro SCAN_MASK_EN: adds ch_mask[7:0]; set bits skip
// channels, an all-ones mask blocks start and ends a running scan.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV   = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              stop,
  input  logic              one_shot,
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  output logic [SEL_W-1:0]  sel,
  output logic              sel_valid,
  output logic              frame_done,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              one_shot_q, one_shot_d;
  logic              frame_done_q, frame_done_d;
  logic              sel_valid_q, sel_valid_d;
  logic              busy_q, busy_d;

  logic              tick;
  logic [NUM_CH-1:0] mask_w;
  ch_pick_t          low_pick;
  ch_pick_t          high_pick;

`ifdef SCAN_MASK_EN
  assign mask_w = ch_mask;
`else
  assign mask_w = '0;
`endif

  // Candidate channels for a frame start and for the next advance.
  assign low_pick  = lowest_unmasked(mask_w);
  assign high_pick = higher_unmasked(mask_w, sel_q);

  tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .nrst (nrst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  // Next-state, channel advance and frame-end decisions.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    one_shot_d   = one_shot_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        // stop has priority over start; an all-masked frame never starts.
        if (start && !stop && low_pick.found) begin
          state_d    = RUN;
          sel_d      = low_pick.ch;
          one_shot_d = one_shot;
        end
      end

      RUN, DRAIN: begin
        if ((state_q == RUN) && stop) begin
          state_d = DRAIN;
        end
        if (tick) begin
          if (high_pick.found) begin
            sel_d = high_pick.ch;
          end else begin
            // Last channel of the frame just finished its dwell.
            frame_done_d = 1'b1;
            // A stop arriving on the wrap edge ends the scan with this frame.
            if ((state_q == DRAIN) || stop || one_shot_q || !low_pick.found) begin
              state_d = IDLE;
              sel_d   = '0;
            end else begin
              sel_d = low_pick.ch;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    sel_valid_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
  end

  // FSM state, select and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      one_shot_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      one_shot_q   <= one_shot_d;
      frame_done_q <= frame_done_d;
      sel_valid_q  <= sel_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: two instances (DIV=2 and DIV=1)
// share stimulus; a dwell/age model checks every cycle, and directed
// literal expectations pin the model. Mask tests run when SCAN_MASK_EN is set.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start, stop, one_shot;
  logic [7:0] ch_mask;
  logic [2:0] sel_a, sel_b;
  logic       sel_valid_a, sel_valid_b, frame_done_a, frame_done_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  scan_sequencer #(.DIV(2), .CNT_W(8)) dut_a (
    .clk(clk), .nrst(nrst), .start(start), .stop(stop), .one_shot(one_shot),
`ifdef SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .sel(sel_a), .sel_valid(sel_valid_a), .frame_done(frame_done_a), .busy(busy_a)
  );

  scan_sequencer #(.DIV(1), .CNT_W(4)) dut_b (
    .clk(clk), .nrst(nrst), .start(start), .stop(stop), .one_shot(one_shot),
`ifdef SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .sel(sel_b), .sel_valid(sel_valid_b), .frame_done(frame_done_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit active;
    bit oneshot;
    bit draining;
    int ch;
    int age;
    bit done;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t s, int div, bit st, bit sp, bit os, logic [7:0] m);
    mdl_t n;
    int   lo;
    int   hi;
    n      = s;
    n.done = 1'b0;
    lo     = -1;
    for (int i = 7; i >= 0; i--) if (!m[i]) lo = i;
    if (!s.active) begin
      if (st && !sp && lo >= 0) begin
        n.active   = 1'b1;
        n.oneshot  = os;
        n.draining = 1'b0;
        n.ch       = lo;
        n.age      = 0;
      end
    end else begin
      if (s.age == div - 1) begin
        n.age = 0;
        hi    = -1;
        for (int i = 7; i > s.ch; i--) if (!m[i]) hi = i;
        if (hi >= 0) begin
          n.ch = hi;
        end else begin
          n.done = 1'b1;
          if (s.oneshot || s.draining || sp || lo < 0) begin
            n.active = 1'b0;
            n.ch     = 0;
          end else begin
            n.ch = lo;
          end
        end
      end else begin
        n.age = s.age + 1;
      end
      if (sp && n.active) n.draining = 1'b1;
    end
    return n;
  endfunction

  logic [7:0] mask_eff;
`ifdef SCAN_MASK_EN
  assign mask_eff = ch_mask;
`else
  assign mask_eff = 8'h00;
`endif

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = step(ma, 2, start, stop, one_shot, mask_eff);
      mb = step(mb, 1, start, stop, one_shot, mask_eff);
    end
  end

  task automatic check_inst(input string tag, input mdl_t s, input int sel_v,
                            input int valid_v, input int fd_v, input int busy_v);
    check({tag, "_sel"},        sel_v,   s.ch);
    check({tag, "_sel_valid"},  valid_v, int'(s.active));
    check({tag, "_frame_done"}, fd_v,    int'(s.done));
    check({tag, "_busy"},       busy_v,  int'(s.active));
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst("mdl_a", ma, sel_a, sel_valid_a, frame_done_a, busy_a);
      check_inst("mdl_b", mb, sel_b, sel_valid_b, frame_done_b, busy_b);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sel_a(input int val, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (sel_a == 3'(val) && busy_a) hit = 1'b1;
    end
    check(name, int'(hit), 1);
  endtask

  task automatic wait_idle(input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) hit = 1'b1;
    end
    check(name, int'(hit), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt;
    int last_sel;
    int prev_sel;
    int k_done;

    nrst     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    one_shot = 1'b0;
    ch_mask  = 8'h00;
    cyc(2);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_sel", sel_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_frame_done", frame_done_a, 0);
    @(posedge clk);
    #1 nrst = 1'b1;
    cyc(2);

    // Test 2: DIV=2 single frame, sel 0,0,1,1..7,7 then frame_done.
    one_shot = 1'b1;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    one_shot = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t2_sel", sel_a, k / 2);
      check("t2_sel_valid", sel_valid_a, 1);
      check("t2_fd_early", frame_done_a, 0);
    end
    @(negedge clk);
    check("t2_fd_pulse", frame_done_a, 1);
    check("t2_busy_after", busy_a, 0);
    check("t2_sel_after", sel_a, 0);
    @(negedge clk);
    check("t2_fd_one_cycle", frame_done_a, 0);
    cyc(1);

    // Test 3: continuous, stop at sel=3 -> finish frame once, then idle.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_sel_a(3, "t3_reach_sel3");
    cyc(0);
    @(posedge clk);
    #1 stop = 1'b1;
    cyc(1);
    stop     = 1'b0;
    fd_cnt   = 0;
    last_sel = -1;
    prev_sel = sel_a;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done_a) begin
        fd_cnt++;
        last_sel = prev_sel;
      end
      prev_sel = sel_a;
    end
    check("t3_fd_count", fd_cnt, 1);
    check("t3_last_sel", last_sel, 7);
    check("t3_busy_end", busy_a, 0);
    cyc(1);

    // Test 4: start+stop together stays idle; start while busy is ignored.
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check("t4_valid_idle", sel_valid_a, 0);
    check("t4_busy_idle", busy_a, 0);
    cyc(1);
    one_shot = 1'b1;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    cyc(3);
    start    = 1'b1;
    one_shot = 1'b0;
    cyc(1);
    start    = 1'b0;
    #3;
    @(negedge clk);
    check("t4_sel_after_start", sel_a, 2);
    k_done = -1;
    for (int k = 5; k < 30 && k_done < 0; k++) begin
      @(negedge clk);
      if (frame_done_a) k_done = k;
    end
    check("t4_fd_cycle", k_done, 16);
    check("t4_oneshot_kept", busy_a, 0);
    wait_idle("t4_idle");
    cyc(1);

    // Test 5: DIV=1 continuous, sel every cycle, frame_done every 8th with no gap.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check("t5_sel", sel_b, k % 8);
      check("t5_fd", frame_done_b, int'(k > 0 && (k % 8) == 0));
    end
    cyc(1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    wait_idle("t5_idle");
    cyc(1);

    // Test 1: asynchronous reset mid-scan at sel=5.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_sel_a(5, "t1_reach_sel5");
    #2 nrst = 1'b0;
    #1;
    check("t1_sel", sel_a, 0);
    check("t1_sel_valid", sel_valid_a, 0);
    check("t1_frame_done", frame_done_a, 0);
    check("t1_busy", busy_a, 0);
    check("t1_b_busy", busy_b, 0);
    cyc(2);
    nrst = 1'b1;
    @(negedge clk);
    check("t1_idle_after", busy_a, 0);
    check("t1_no_fd", frame_done_a, 0);
    cyc(2);

`ifdef SCAN_MASK_EN
    // Test 6: masked channels skipped; all-ones mask blocks start.
    begin
      int exp_seq [4];
      exp_seq  = '{1, 3, 4, 6};
      ch_mask  = 8'hA5;
      one_shot = 1'b1;
      start    = 1'b1;
      cyc(1);
      start    = 1'b0;
      one_shot = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check("t6_sel", sel_a, exp_seq[k / 2]);
      end
      @(negedge clk);
      check("t6_fd", frame_done_a, 1);
      check("t6_busy_after", busy_a, 0);
      wait_idle("t6_idle");
      cyc(1);
      ch_mask = 8'hFF;
      start   = 1'b1;
      cyc(1);
      start   = 1'b0;
      @(negedge clk);
      check("t6_ff_busy", busy_a, 0);
      check("t6_ff_valid", sel_valid_a, 0);
      cyc(1);
      ch_mask = 8'h00;
    end
`endif

    cyc(4);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
